// File: rtl/branch_resolve_unit.sv
// Branch resolution: samples comparator flags at accept, decides the branch,
// then issues a one-cycle PC load and holds flush while fetch is redirected.
module branch_resolve_unit #(
  parameter int PC_W         = 16,
  parameter int OFF_W        = 8,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             br_valid,
  output logic             br_ready,
  input  logic [1:0]       br_op,
  input  logic [PC_W-1:0]  br_pc,
  input  logic [OFF_W-1:0] br_off,
  input  logic             lt,
  input  logic             gt,
  input  logic             equal,
  output logic             br_done,
  output logic             taken,
  output logic             pc_load,
  output logic [PC_W-1:0]  pc_target,
  output logic             flush,
  output logic             flag_err
);

  localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, EVAL, REDIRECT} state_t;

  localparam logic [1:0] OP_BEQ = 2'b00;
  localparam logic [1:0] OP_BLT = 2'b01;
  localparam logic [1:0] OP_BGT = 2'b10;
  localparam logic [1:0] OP_JMP = 2'b11;

  state_t             state, state_n;
  logic [1:0]         op_q;
  logic [PC_W-1:0]    pc_q;
  logic [OFF_W-1:0]   off_q;
  logic               lt_q, gt_q, eq_q;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic               br_done_n, taken_n, pc_load_n, flush_n, flag_err_n;
  logic [PC_W-1:0]    pc_target_n;
  logic               accept;
  logic               one_hot;
  logic               cond;
  logic               bad_flags;
  logic [PC_W-1:0]    target_calc;

  assign br_ready = (state == IDLE) & ~reset;
  assign accept   = br_valid & br_ready;

  // Flags are only trusted when exactly one of them is set.
  assign one_hot     = ({lt_q, gt_q, eq_q} == 3'b100) |
                       ({lt_q, gt_q, eq_q} == 3'b010) |
                       ({lt_q, gt_q, eq_q} == 3'b001);
  assign bad_flags   = (op_q != OP_JMP) & ~one_hot;
  assign target_calc = pc_q + PC_W'($signed(off_q));

  always_comb begin
    cond = 1'b0;
    case (op_q)
      OP_BEQ:  cond = eq_q & one_hot;
      OP_BLT:  cond = lt_q & one_hot;
      OP_BGT:  cond = gt_q & one_hot;
      OP_JMP:  cond = 1'b1;
      default: cond = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      br_done   <= 1'b0;
      taken     <= 1'b0;
      pc_load   <= 1'b0;
      pc_target <= '0;
      flush     <= 1'b0;
      flag_err  <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      br_done   <= br_done_n;
      taken     <= taken_n;
      pc_load   <= pc_load_n;
      pc_target <= pc_target_n;
      flush     <= flush_n;
      flag_err  <= flag_err_n;
    end
  end

  // Request fields and flags are frozen at accept; later flag changes are ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q  <= '0;
      pc_q  <= '0;
      off_q <= '0;
      lt_q  <= 1'b0;
      gt_q  <= 1'b0;
      eq_q  <= 1'b0;
    end else if (accept) begin
      op_q  <= br_op;
      pc_q  <= br_pc;
      off_q <= br_off;
      lt_q  <= lt;
      gt_q  <= gt;
      eq_q  <= equal;
    end
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    br_done_n   = 1'b0;
    taken_n     = 1'b0;
    pc_load_n   = 1'b0;
    pc_target_n = pc_target;
    flush_n     = flush;
    flag_err_n  = flag_err;
    case (state)
      IDLE: begin
        if (accept) state_n = EVAL;
      end
      EVAL: begin
        br_done_n = 1'b1;
        taken_n   = cond;
        if (bad_flags) flag_err_n = 1'b1;
        if (cond) begin
          pc_load_n   = 1'b1;
          pc_target_n = target_calc;
          flush_n     = 1'b1;
          cnt_n       = CNT_W'(FLUSH_CYCLES - 1);
          state_n     = REDIRECT;
        end else begin
          flush_n = 1'b0;
          state_n = IDLE;
        end
      end
      REDIRECT: begin
        if (cnt == '0) begin
          flush_n = 1'b0;
          state_n = IDLE;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Testbench for branch_resolve_unit: directed vectors with literal checks,
// plus a cycle-timeline model compared against every output each cycle.
module tb_branch_resolve_unit;

  localparam int PC_W  = 16;
  localparam int OFF_W = 8;
  localparam int FLUSH = 2;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             br_valid = 1'b0;
  logic             br_ready;
  logic [1:0]       br_op = 2'b00;
  logic [PC_W-1:0]  br_pc = '0;
  logic [OFF_W-1:0] br_off = '0;
  logic             lt = 1'b0, gt = 1'b0, equal = 1'b0;
  logic             br_done, taken, pc_load, flush, flag_err;
  logic [PC_W-1:0]  pc_target;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit check_en = 1'b0;

  branch_resolve_unit #(.PC_W(PC_W), .OFF_W(OFF_W), .FLUSH_CYCLES(FLUSH)) dut (
    .clk(clk), .reset(reset), .br_valid(br_valid), .br_ready(br_ready),
    .br_op(br_op), .br_pc(br_pc), .br_off(br_off), .lt(lt), .gt(gt),
    .equal(equal), .br_done(br_done), .taken(taken), .pc_load(pc_load),
    .pc_target(pc_target), .flush(flush), .flag_err(flag_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Model: an accept at cycle N schedules the result for N+2 and, when
  // taken, flush over N+2..N+1+FLUSH with the next accept at N+2+FLUSH.
  int              ready_at = 0;
  int              res_cycle = -1;
  int              fs = 0;
  int              fe = -1;
  logic            m_cond = 1'b0;
  logic            m_err_pend = 1'b0;
  logic            m_err = 1'b0;
  logic [PC_W-1:0] m_tgt = '0;
  logic [PC_W-1:0] pend_tgt = '0;

  function automatic logic model_taken(input logic [1:0] op, input logic l, g, e);
    int n;
    n = int'(l) + int'(g) + int'(e);
    if (op == 2'b11) return 1'b1;
    if (n != 1) return 1'b0;
    case (op)
      2'b00:   return e;
      2'b01:   return l;
      default: return g;
    endcase
  endfunction

  task automatic model_clear();
    ready_at   = 0;
    res_cycle  = -1;
    fs         = 0;
    fe         = -1;
    m_cond     = 1'b0;
    m_err_pend = 1'b0;
    m_err      = 1'b0;
    m_tgt      = '0;
  endtask

  always @(posedge reset) model_clear();

  always @(posedge clk) begin
    if (reset) begin
      model_clear();
    end else if (cyc >= ready_at && br_valid) begin
      m_cond     = model_taken(br_op, lt, gt, equal);
      m_err_pend = (br_op != 2'b11) && ((int'(lt) + int'(gt) + int'(equal)) != 1);
      pend_tgt   = PC_W'(int'(br_pc) + int'($signed(br_off)));
      res_cycle  = cyc + 2;
      if (m_cond) begin
        fs       = cyc + 2;
        fe       = cyc + 1 + FLUSH;
        ready_at = cyc + 2 + FLUSH;
      end else begin
        fs       = 0;
        fe       = -1;
        ready_at = cyc + 2;
      end
    end
    cyc++;
    if (!reset && cyc == res_cycle) begin
      if (m_cond) m_tgt = pend_tgt;
      if (m_err_pend) m_err = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("m_br_ready", br_ready, !reset && cyc >= ready_at);
      checkOutput("m_br_done", br_done, cyc == res_cycle);
      checkOutput("m_taken", taken, (cyc == res_cycle) && m_cond);
      checkOutput("m_pc_load", pc_load, (cyc == res_cycle) && m_cond);
      checkOutput("m_flush", flush, cyc >= fs && cyc <= fe);
      checkOutput("m_pc_target", pc_target, m_tgt);
      checkOutput("m_flag_err", flag_err, m_err);
    end
  end

  // Presents a request and holds it until the unit accepts; n is the accept cycle.
  task automatic applyStimulus(input logic [1:0] op, input logic [PC_W-1:0] pc,
                               input logic [OFF_W-1:0] off, input logic l, g, e,
                               output int n);
    @(negedge clk);
    br_valid = 1'b1;
    br_op    = op;
    br_pc    = pc;
    br_off   = off;
    lt       = l;
    gt       = g;
    equal    = e;
    for (int i = 0; i < 20; i++) begin
      if (br_ready) break;
      @(negedge clk);
    end
    checkOutput("accept_wait", br_ready, 1);
    n = cyc;
    @(negedge clk);
    br_valid = 1'b0;
  endtask

  initial begin
    #100000;
    errors++;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    int n;
    int m;
    int phase;

    #1 reset = 1'b1;
    #1;
    check_en = 1'b1;
    checkOutput("rst_ready", br_ready, 0);
    checkOutput("rst_done", br_done, 0);
    checkOutput("rst_flush", flush, 0);
    checkOutput("rst_target", pc_target, 0);
    checkOutput("rst_err", flag_err, 0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    checkOutput("ready_after_reset", br_ready, 1);

    $display("[TB] BEQ taken");
    applyStimulus(2'b00, 16'h0010, 8'h04, 1'b0, 1'b0, 1'b1, n);
    @(negedge clk);
    checkOutput("t1_done", br_done, 1);
    checkOutput("t1_taken", taken, 1);
    checkOutput("t1_pc_load", pc_load, 1);
    checkOutput("t1_target", pc_target, 16'h0014);
    checkOutput("t1_flush_n2", flush, 1);
    @(negedge clk);
    checkOutput("t1_flush_n3", flush, 1);
    checkOutput("t1_pulse_end", pc_load, 0);
    checkOutput("t1_ready_n3", br_ready, 0);
    @(negedge clk);
    checkOutput("t1_ready_n4", br_ready, 1);
    checkOutput("t1_flush_n4", flush, 0);

    $display("[TB] BLT not taken");
    applyStimulus(2'b01, 16'h0100, 8'h08, 1'b0, 1'b1, 1'b0, n);
    @(negedge clk);
    checkOutput("t2_done", br_done, 1);
    checkOutput("t2_taken", taken, 0);
    checkOutput("t2_pc_load", pc_load, 0);
    checkOutput("t2_flush", flush, 0);
    checkOutput("t2_target", pc_target, 16'h0014);
    checkOutput("t2_ready", br_ready, 1);

    $display("[TB] JMP wrap and negative offset");
    applyStimulus(2'b11, 16'hFFFE, 8'h05, 1'b0, 1'b0, 1'b0, n);
    @(negedge clk);
    checkOutput("t3_wrap_target", pc_target, 16'h0003);
    applyStimulus(2'b11, 16'h0040, 8'h80, 1'b0, 1'b0, 1'b0, n);
    @(negedge clk);
    checkOutput("t3_neg_target", pc_target, 16'hFFC0);

    $display("[TB] bad flags");
    applyStimulus(2'b10, 16'h0200, 8'h10, 1'b1, 1'b1, 1'b0, n);
    @(negedge clk);
    checkOutput("t4_taken", taken, 0);
    checkOutput("t4_done", br_done, 1);
    checkOutput("t4_err", flag_err, 1);
    applyStimulus(2'b11, 16'h1000, 8'h10, 1'b0, 1'b0, 1'b0, n);
    @(negedge clk);
    checkOutput("t4_jmp_taken", taken, 1);
    checkOutput("t4_jmp_target", pc_target, 16'h1010);
    checkOutput("t4_err_sticky", flag_err, 1);

    $display("[TB] reset during redirect");
    applyStimulus(2'b11, 16'h2000, 8'h02, 1'b0, 1'b0, 1'b0, n);
    @(posedge clk);
    #1;
    checkOutput("t5_pre_load", pc_load, 1);
    reset = 1'b1;
    #1;
    checkOutput("t5_flush", flush, 0);
    checkOutput("t5_pc_load", pc_load, 0);
    checkOutput("t5_done", br_done, 0);
    checkOutput("t5_err_cleared", flag_err, 0);
    @(posedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    checkOutput("t5_ready", br_ready, 1);
    checkOutput("t5_no_late_done", br_done, 0);
    @(negedge clk);
    checkOutput("t5_no_late_load", pc_load, 0);

    $display("[TB] held request with toggling flags");
    applyStimulus(2'b11, 16'h3000, 8'h10, 1'b0, 1'b0, 1'b0, n);
    br_valid = 1'b1;
    br_op    = 2'b00;
    br_pc    = 16'h4000;
    br_off   = 8'h04;
    phase    = 0;
    for (int i = 0; i < 20; i++) begin
      equal = (phase == 0);
      lt    = (phase != 0);
      gt    = 1'b0;
      if (br_ready) break;
      @(negedge clk);
      phase ^= 1;
    end
    checkOutput("t6_accept_wait", br_ready, 1);
    m = cyc;
    checkOutput("t6_accept_cycle", m - n, 4);
    @(negedge clk);
    br_valid = 1'b0;
    equal    = 1'b1;
    lt       = 1'b0;
    @(negedge clk);
    checkOutput("t6_done", br_done, 1);
    checkOutput("t6_taken", taken, 0);
    checkOutput("t6_target", pc_target, 16'h3010);

    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
